// File: rtl/imem_fetch_if.sv
// rtl/imem_fetch_if.sv - fetch controller bus: control inputs, imem request/response, decode handshake
interface imem_fetch_if;
  logic        en_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        err_o;

  modport master (
    input  en_i, redirect_i, redirect_pc_i, imem_instr_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, err_o
  );

  modport slave (
    output en_i, redirect_i, redirect_pc_i, imem_instr_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, err_o
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch PC sequencer with fixed-latency response tracking and instruction FIFO
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          MEM_LAT    = 1,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MEM_WORDS  = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  imem_fetch_if.master bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + MEM_LAT + 1) + 1;
  localparam logic [31:0]   PC_LAST  = 32'(MEM_WORDS * 4 - 4);
  localparam logic [31:0]   PC_LIMIT = 32'(MEM_WORDS * 4);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_next;
  logic          epoch;
  logic          err;

  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] need;

  logic          valid;
  logic          pop;
  logic          push;
  logic          issue;
  logic          redirect_take;
  logic          redirect_bad;
  logic          mature_push;
  logic [31:0]   mature_pc;
  logic [31:0]   mature_instr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign redirect_take = bus.redirect_i && (state != S_HALT);
  assign redirect_bad  = (bus.redirect_pc_i[1:0] != 2'b00) || (bus.redirect_pc_i >= PC_LIMIT);
  assign pc_next       = (fetch_pc == PC_LAST) ? 32'h0 : fetch_pc + 32'd4;

  // Reset gates the outputs so they read as reset values during the reset cycle itself.
  assign valid = (count != '0) && !rst_i;
  assign pop   = valid && bus.instr_ready_i && !bus.redirect_i;
  assign push  = mature_push && (state != S_HALT);

  // Credit check: in-flight plus buffered (after this cycle's pop) must leave room.
  always_comb begin
    need  = inflight + count - CW'(pop);
    issue = !rst_i && (state == S_RUN) && bus.en_i && !bus.redirect_i && (need < DEPTH_C);
  end

  generate
    if (MEM_LAT == 0) begin : g_comb_mem
      assign inflight     = '0;
      assign mature_push  = issue;
      assign mature_pc    = fetch_pc;
      assign mature_instr = bus.imem_instr_i;
    end else begin : g_tag_pipe
      logic [MEM_LAT-1:0] tag_v;
      logic [MEM_LAT-1:0] tag_e;
      logic [31:0]        tag_pc [MEM_LAT];

      // Tag shift register; valids are also cleared on redirect because a 1-bit
      // epoch would alias across two back-to-back redirects with MEM_LAT > 2.
      always_ff @(posedge clk_i) begin
        if (rst_i || redirect_take) begin
          tag_v <= '0;
        end else begin
          tag_v[0] <= issue;
          for (int i = 1; i < MEM_LAT; i++) tag_v[i] <= tag_v[i-1];
        end
        tag_e[0]  <= epoch;
        tag_pc[0] <= fetch_pc;
        for (int i = 1; i < MEM_LAT; i++) begin
          tag_e[i]  <= tag_e[i-1];
          tag_pc[i] <= tag_pc[i-1];
        end
      end

      // Count outstanding requests for the credit check.
      always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) inflight = inflight + CW'(tag_v[i]);
      end

      assign mature_push  = tag_v[MEM_LAT-1] && (tag_e[MEM_LAT-1] == epoch);
      assign mature_pc    = tag_pc[MEM_LAT-1];
      assign mature_instr = bus.imem_instr_i;
    end
  endgenerate

  // Control FSM: fetch PC, epoch, sticky error; redirect beats issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_RUN;
      fetch_pc <= RESET_PC;
      epoch    <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_RUN, S_FLUSH: begin
          if (bus.redirect_i) begin
            if (redirect_bad) begin
              state <= S_HALT;
              err   <= 1'b1;
            end else begin
              fetch_pc <= bus.redirect_pc_i;
              epoch    <= ~epoch;
              state    <= S_FLUSH;
            end
          end else begin
            if (state == S_FLUSH) state <= S_RUN;
            if (issue) fetch_pc <= pc_next;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Instruction FIFO; emptied on reset, redirect and while halted.
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_take || (state == S_HALT)) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= mature_instr;
        fifo_pc[wr_ptr]    <= mature_pc;
        wr_ptr             <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign bus.imem_req_o    = issue;
  assign bus.imem_addr_o   = rst_i ? RESET_PC : fetch_pc;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o       = valid ? fifo_instr[rd_ptr] : 32'h0;
  assign bus.instr_pc_o    = valid ? fifo_pc[rd_ptr] : 32'h0;
  assign bus.err_o         = err && !rst_i;

endmodule
